hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Execute-stage HI/LO unit. It consumes the main decoder's hilowrite code together with the ALU-stage multiply/divide select, and owns the architectural HI and LO registers.
- MULT and MULTU complete in one cycle. DIV and DIVU use an iterative 32-step restoring divider and stall the pipeline while it runs.
- MTHI and MTLO write HI or LO directly. MFHI and MFLO read the hi and lo outputs.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- DIV_STEPS, WIDTH, divider iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- hilowrite  in  2  from decoder: 00 none, 01 write LO, 10 write HI, 11 mult/div request.
- mdop  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid only when hilowrite=11.
- a  in  WIDTH  rs operand (dividend, or MTHI/MTLO source).
- b  in  WIDTH  rt operand (divisor).
- cancel  in  1  EX flush (exception or branch squash); aborts a running divide.
- stall  out  1  combinational; holds IF/ID/EX while high.
- hi  out  WIDTH  registered HI.
- lo  out  WIDTH  registered LO.

Behaviour:
- Reset: hi=0, lo=0, state=IDLE, stall=0, iteration counter=0, divider datapath registers=0.
- States: IDLE, BUSY, DONE.

IDLE state:
- hilowrite=10: hi<=a at the next edge. hilowrite=01: lo<=a. No stall.
- hilowrite=11 with MULT: {hi,lo}<=signed a*b (64-bit). With MULTU: unsigned product. Result is visible the next cycle; no stall.
- hilowrite=11 with DIV or DIVU and cancel=0:
  - stall=1 combinationally in the same cycle.
  - Latch |a| and |b| (signed) or a and b (unsigned), plus sign flags qneg=a[31]^b[31] and rneg=a[31] (signed only).
  - Counter<=0; go to BUSY.

BUSY state:
- stall=1. One restoring shift/subtract step per cycle; counter increments.
- After step DIV_STEPS, apply signs: quotient negated if qneg, remainder negated if rneg. Then lo<=quotient, hi<=remainder, and go to DONE.
- Latency: request in cycle N; BUSY covers cycles N+1..N+32; hi/lo are updated at the edge ending N+32.

DONE state:
- stall=0 for exactly one cycle so the divide instruction can leave EX.
- Any hilowrite=11 in this cycle is the same instruction and is ignored. MTHI/MTLO are also ignored in DONE.
- Go to IDLE.

Boundary conditions:
- Divide by zero (b=0): still takes 32 cycles. Result is quotient=all ones and remainder=dividend, with sign fix-up applied after the raw division for the signed case.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- DIVU uses no sign fix-up.
- cancel=1 in BUSY: go to IDLE next edge, stall=0 in the following cycle, hi/lo unchanged.
- cancel=1 in IDLE with a request: the request is not accepted; hi/lo unchanged; stall=0.
- cancel has no effect in DONE.
- rst mid-divide: IDLE with all reset values next edge.
- hilowrite is ignored while BUSY.
- Two back-to-back DIVs: the second is accepted from IDLE, at the earliest 2 cycles after the first's final step.

Decomposition:
- Shared defines header holds the hilowrite encodings (NONE/LO/HI/MULDIV), the mdop encodings (MULT/MULTU/DIV/DIVU) and the FSM state encodings.
- One sub-module, div_iter, contains the restoring divider (load, step, counter, done pulse, abort).
- Multiply, the sign fix-up and the HI/LO registers stay in hilo_muldiv.

Test Plan:
1. MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> hi=0x12345678 and lo=0x9ABCDEF0 one cycle after each; stall never high.
2. MULT a=0xFFFFFFFE (-2), b=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. DIV a=-7 (0xFFFFFFF9), b=2 -> stall high for exactly 33 cycles (request cycle plus 32), then lo=0xFFFFFFFD and hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
5. DIVU started with hi=lo=0xAAAAAAAA, cancel pulsed at BUSY cycle 10 -> stall drops the following cycle; hi/lo stay 0xAAAAAAAA; a new DIVU 9/3 afterwards gives lo=3, hi=0.
6. rst asserted at BUSY cycle 20 -> next cycle hi=lo=0, stall=0, state IDLE. A request held through DONE -> exactly one divide is performed.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg
// Shared encodings for the HI/LO multiply/divide unit:
//   - hilowrite codes coming from the main decoder
//   - mdop codes selecting the multiply/divide operation
//   - FSM state encoding of the HI/LO unit
package hilo_muldiv_pkg;

    // hilowrite encodings
    localparam logic [1:0] HW_NONE   = 2'b00;
    localparam logic [1:0] HW_LO     = 2'b01;
    localparam logic [1:0] HW_HI     = 2'b10;
    localparam logic [1:0] HW_MULDIV = 2'b11;

    // mdop encodings (meaningful only with HW_MULDIV)
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// hilo_muldiv_div_iter
// Iterative restoring divider, one quotient bit per cycle on unsigned
// operands. Sign handling is done by the caller.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   load            capture dividend/divisor, clear the step counter
//   run             perform one shift/subtract step this cycle
//   abort           drop the current division (counter cleared)
//   dividend        unsigned dividend to latch on load
//   divisor         unsigned divisor to latch on load
//   quotient        quotient after this cycle's step (valid when last=1)
//   remainder       remainder after this cycle's step (valid when last=1)
//   last            high during the cycle that performs the final step
module hilo_muldiv_div_iter
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CNT_W = $clog2(DIV_STEPS + 1);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;     // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // The partial remainder stays below the divisor, so the shifted value
    // minus the divisor never exceeds WIDTH bits; bit WIDTH of the trial is
    // therefore a clean borrow flag. A zero divisor never borrows, which
    // naturally yields quotient=all ones and remainder=dividend.
    always_comb begin
        shifted = {rem_r, quo_r[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_r};
        if (trial[WIDTH]) begin
            rem_nx = shifted[WIDTH-1:0];
            quo_nx = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo_r[WIDTH-2:0], 1'b1};
        end
    end

    assign quotient  = quo_nx;
    assign remainder = rem_nx;
    assign last      = run && (count == CNT_W'(DIV_STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r <= '0;
            quo_r <= '0;
            dvs_r <= '0;
            count <= '0;
        end else if (load) begin
            rem_r <= '0;
            quo_r <= dividend;
            dvs_r <= divisor;
            count <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (run) begin
            rem_r <= rem_nx;
            quo_r <= quo_nx;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// Execute-stage HI/LO unit. Owns the architectural HI and LO registers,
// performs single-cycle MULT/MULTU, iterative DIV/DIVU (stalling the
// pipeline), and direct MTHI/MTLO writes.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   hilowrite   00 none, 01 write LO, 10 write HI, 11 mult/div request
//   mdop        00 MULT, 01 MULTU, 10 DIV, 11 DIVU (used with hilowrite=11)
//   a           rs operand: dividend / multiplicand / MTHI-MTLO source
//   b           rt operand: divisor / multiplier
//   cancel      EX flush; rejects a new divide, aborts a running one
//   stall       combinational pipeline hold
//   hi, lo      registered HI and LO
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       hilowrite,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e state;
    logic   qneg;
    logic   rneg;

    logic                      is_div;
    logic                      signed_div;
    logic                      start;
    logic [WIDTH-1:0]          div_a;
    logic [WIDTH-1:0]          div_b;
    logic [WIDTH-1:0]          quo;
    logic [WIDTH-1:0]          rem;
    logic                      last;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? -v : v;
    endfunction

    assign is_div     = (hilowrite == HW_MULDIV) && ((mdop == MD_DIV) || (mdop == MD_DIVU));
    assign signed_div = (mdop == MD_DIV);
    assign start      = (state == ST_IDLE) && is_div && !cancel;
    assign stall      = start || (state == ST_BUSY);

    // Signed magnitudes; 0x80000000 maps to itself, which is the correct
    // unsigned magnitude 2^31.
    assign div_a = signed_div ? magnitude(a) : a;
    assign div_b = signed_div ? magnitude(b) : b;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    hilo_muldiv_div_iter #(
        .WIDTH     (WIDTH),
        .DIV_STEPS (DIV_STEPS)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (start),
        .run       (state == ST_BUSY),
        .abort     ((state == ST_BUSY) && cancel),
        .dividend  (div_a),
        .divisor   (div_b),
        .quotient  (quo),
        .remainder (rem),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (hilowrite)
                        HW_HI: hi <= a;
                        HW_LO: lo <= a;
                        HW_MULDIV: begin
                            if (mdop == MD_MULT) begin
                                {hi, lo} <= $unsigned(prod_s);
                            end else if (mdop == MD_MULTU) begin
                                {hi, lo} <= prod_u;
                            end else if (start) begin
                                qneg  <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                                rneg  <= signed_div && a[WIDTH-1];
                                state <= ST_BUSY;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_BUSY: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        lo    <= apply_sign(quo, qneg);
                        hi    <= apply_sign(rem, rneg);
                        state <= ST_DONE;
                    end
                end
                // One stall-free cycle lets the divide leave EX; its still
                // present request and any HI/LO write are ignored here.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hilowrite;
    logic [1:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    hilo_muldiv #(
        .WIDTH     (32),
        .DIV_STEPS (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hilowrite (hilowrite),
        .mdop      (mdop),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_mul(input logic [31:0] x, input logic [31:0] y,
                                              input bit sgn);
        longint          ps;
        longint unsigned pu;
        ps = longint'($signed(x)) * longint'($signed(y));
        pu = longint'({32'b0, x}) * longint'({32'b0, y});
        return sgn ? ps : pu;
    endfunction

    // returns {hi, lo} = {remainder, quotient}
    function automatic logic [63:0] model_div(input logic [31:0] x, input logic [31:0] y,
                                              input bit sgn);
        longint sx, sy, ux, uy, q, r;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end
        ux = (sx < 0) ? -sx : sx;
        uy = (sy < 0) ? -sy : sy;
        if (uy == 0) begin
            q = 64'h0000_0000_FFFF_FFFF;
            r = ux;
        end else begin
            q = ux / uy;
            r = ux % uy;
        end
        if (sgn && (x[31] ^ y[31])) q = -q;
        if (sgn && x[31])           r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // ---------------- drive helpers ----------------
    task automatic drive(input logic [1:0] hw, input logic [1:0] md,
                         input logic [31:0] x, input logic [31:0] y);
        hilowrite = hw;
        mdop      = md;
        a         = x;
        b         = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a divide and holds it through the stall and the DONE cycle,
    // in which done_hw/done_a are presented instead. Returns the number of
    // stalled cycles; returns one cycle after DONE with hilowrite=none.
    task automatic do_div(input logic [1:0] md, input logic [31:0] x, input logic [31:0] y,
                          input logic [1:0] done_hw, input logic [31:0] done_a,
                          output int n);
        drive(2'b11, md, x, y);
        n = 0;
        forever begin
            #1;
            if (!stall || n >= 100) break;
            n++;
            @(posedge clk);
        end
        hilowrite = done_hw;
        a         = done_a;
        step();
        hilowrite = 2'b00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst    = 1'b1;
        cancel = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        repeat (3) step();
        rst = 1'b0;
        #1;
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] eh, el, v;
        drive(2'b10, 2'b11, 32'h1234_5678, 32'hFFFF_FFFF);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", stall); end
        step();
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi got=%h exp=%h", hi, 32'h1234_5678); end
        drive(2'b01, 2'b10, 32'h9ABC_DEF0, 32'h0);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mtlo_stall got=%b exp=0", stall); end
        step();
        checks++; if (lo !== 32'h9ABC_DEF0) begin failures++; $display("FAIL mtlo got=%h exp=%h", lo, 32'h9ABC_DEF0); end
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_keeps_hi got=%h exp=%h", hi, 32'h1234_5678); end
        eh = hi;
        el = lo;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                drive(2'b10, 2'($urandom), v, $urandom);
                eh = v;
            end else begin
                drive(2'b01, 2'($urandom), v, $urandom);
                el = v;
            end
            step();
            checks++; if (hi !== eh || lo !== el) begin failures++; $display("FAIL rand_mt got=%h_%h exp=%h_%h", hi, lo, eh, el); end
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_mult();
        logic [63:0] e;
        logic [31:0] x, y;
        bit          sgn;
        drive(2'b11, 2'b00, 32'hFFFF_FFFE, 32'd3);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mult_stall got=%b exp=0", stall); end
        step();
        hilowrite = 2'b00;
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin failures++; $display("FAIL mult got=%h_%h exp=FFFFFFFF_FFFFFFFA", hi, lo); end
        drive(2'b11, 2'b01, 32'hFFFF_FFFE, 32'd3);
        step();
        hilowrite = 2'b00;
        checks++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin failures++; $display("FAIL multu got=%h_%h exp=00000002_FFFFFFFA", hi, lo); end
        for (int i = 0; i < 16; i++) begin
            x   = $urandom;
            y   = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
            sgn = (i % 2 == 0);
            drive(2'b11, sgn ? 2'b00 : 2'b01, x, y);
            e = model_mul(x, y, sgn);
            step();
            hilowrite = 2'b00;
            checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL rand_mult s=%0d a=%h b=%h got=%h_%h exp=%h", sgn, x, y, hi, lo, e); end
        end
    endtask

    task automatic test_div();
        int          n;
        logic [63:0] e;
        logic [31:0] x, y;
        bit          sgn;
        do_div(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b11, 32'hFFFF_FFF9, n);
        checks++; if (n != 33) begin failures++; $display("FAIL div_stall_cycles got=%0d exp=33", n); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_neg7_2 got=%h_%h exp=FFFFFFFF_FFFFFFFD", hi, lo); end
        do_div(2'b11, 32'd100, 32'd7, 2'b11, 32'd100, n);
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL divu_100_7 got=%h_%h exp=00000002_0000000e", hi, lo); end
        for (int i = 0; i < 20; i++) begin
            sgn = (i % 2 == 0);
            x   = $urandom;
            case (i % 5)
                0:       y = 32'h0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = sgn ? -32'($urandom_range(1, 300)) : 32'($urandom_range(1, 300));
                default: y = $urandom;
            endcase
            e = model_div(x, y, sgn);
            do_div(sgn ? 2'b10 : 2'b11, x, y, 2'b11, x, n);
            checks++; if (n != 33) begin failures++; $display("FAIL rand_div_cycles got=%0d exp=33", n); end
            checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL rand_div s=%0d a=%h b=%h got=%h_%h exp=%h", sgn, x, y, hi, lo, e); end
        end
    endtask

    task automatic test_div_boundary();
        int n;
        do_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'h8000_0000, n);
        checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL div_min_neg1 got=%h_%h exp=00000000_80000000", hi, lo); end
        do_div(2'b11, 32'd5, 32'd0, 2'b11, 32'd5, n);
        checks++; if (n != 33) begin failures++; $display("FAIL divu_zero_cycles got=%0d exp=33", n); end
        checks++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin failures++; $display("FAIL divu_5_0 got=%h_%h exp=00000005_FFFFFFFF", hi, lo); end
        do_div(2'b10, 32'hFFFF_FFF6, 32'd0, 2'b11, 32'hFFFF_FFF6, n);
        checks++; if ({hi, lo} !== 64'hFFFF_FFF6_0000_0001) begin failures++; $display("FAIL div_neg10_0 got=%h_%h exp=FFFFFFF6_00000001", hi, lo); end
        // HI write presented during DONE must be ignored
        do_div(2'b11, 32'd50, 32'd8, 2'b10, 32'h5555_5555, n);
        checks++; if ({hi, lo} !== {32'd2, 32'd6}) begin failures++; $display("FAIL done_ignores_mthi got=%h_%h exp=00000002_00000006", hi, lo); end
    endtask

    task automatic test_cancel();
        int n;
        drive(2'b10, 2'b00, 32'hAAAA_AAAA, 32'h0); step();
        drive(2'b01, 2'b00, 32'hAAAA_AAAA, 32'h0); step();
        // cancel together with a fresh request in IDLE: not accepted
        drive(2'b11, 2'b11, 32'd77, 32'd5);
        cancel = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_cancel_stall got=%b exp=0", stall); end
        step();
        cancel    = 1'b0;
        hilowrite = 2'b00;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_cancel_busy got=%b exp=0", stall); end
        checks++; if ({hi, lo} !== 64'hAAAA_AAAA_AAAA_AAAA) begin failures++; $display("FAIL idle_cancel_hilo got=%h_%h exp=AAAAAAAA_AAAAAAAA", hi, lo); end
        // cancel in BUSY cycle 10
        drive(2'b11, 2'b11, 32'd1000, 32'd3);
        step();
        hilowrite = 2'b00;
        repeat (9) step();
        cancel = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL busy_cancel_cycle_stall got=%b exp=1", stall); end
        step();
        cancel = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL busy_cancel_stall got=%b exp=0", stall); end
        repeat (30) step();
        checks++; if ({hi, lo} !== 64'hAAAA_AAAA_AAAA_AAAA) begin failures++; $display("FAIL busy_cancel_hilo got=%h_%h exp=AAAAAAAA_AAAAAAAA", hi, lo); end
        do_div(2'b11, 32'd9, 32'd3, 2'b11, 32'd9, n);
        checks++; if (n != 33) begin failures++; $display("FAIL after_cancel_cycles got=%0d exp=33", n); end
        checks++; if ({hi, lo} !== {32'd0, 32'd3}) begin failures++; $display("FAIL after_cancel_div got=%h_%h exp=00000000_00000003", hi, lo); end
    endtask

    task automatic test_rst_mid();
        int n;
        drive(2'b10, 2'b00, 32'h0BAD_F00D, 32'h0); step();
        drive(2'b01, 2'b00, 32'hCAFE_0001, 32'h0); step();
        drive(2'b11, 2'b10, 32'hFFFF_0000, 32'd13);
        repeat (20) step();
        hilowrite = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=0", hi, lo); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
        drive(2'b01, 2'b00, 32'h77, 32'h0);
        step();
        hilowrite = 2'b00;
        checks++; if (lo !== 32'h77) begin failures++; $display("FAIL rst_mid_idle_mtlo got=%h exp=00000077", lo); end
        do_div(2'b10, 32'hFFFF_FF9C, 32'd7, 2'b11, 32'hFFFF_FF9C, n);
        checks++; if (n != 33) begin failures++; $display("FAIL rst_mid_next_cycles got=%0d exp=33", n); end
        checks++; if ({hi, lo} !== model_div(32'hFFFF_FF9C, 32'd7, 1'b1)) begin failures++; $display("FAIL rst_mid_next_div got=%h_%h", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        do_div(2'b10, 32'd100, 32'hFFFF_FFF9, 2'b11, 32'd100, n1);
        checks++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFF2) begin failures++; $display("FAIL b2b_first got=%h_%h exp=00000002_FFFFFFF2", hi, lo); end
        do_div(2'b11, 32'hFFFF_FFFF, 32'd16, 2'b11, 32'hFFFF_FFFF, n2);
        checks++; if (n2 != 33) begin failures++; $display("FAIL b2b_second_cycles got=%0d exp=33", n2); end
        checks++; if ({hi, lo} !== 64'h0000_000F_0FFF_FFFF) begin failures++; $display("FAIL b2b_second got=%h_%h exp=0000000F_0FFFFFFF", hi, lo); end
        // request was held through DONE: exactly one divide, no restart
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_no_restart got=%b exp=0", stall); end
        repeat (3) step();
        checks++; if ({hi, lo} !== 64'h0000_000F_0FFF_FFFF) begin failures++; $display("FAIL b2b_hold got=%h_%h exp=0000000F_0FFFFFFF", hi, lo); end
    endtask

    initial begin
        rst    = 1'b1;
        cancel = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_div_boundary();
        test_cancel();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
